// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the receive frame controller.
package rx_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    EVAL    = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam int          MCAST_BIT = 40;

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
  } hdr_t;
endpackage

// File: rtl/mac_addr_filter.sv
// Destination-MAC acceptance: unicast to station, broadcast, multicast (if enabled) or promiscuous.
// Purely combinational, no backpressure.
module mac_addr_filter
  import rx_ctrl_pkg::*;
(
  input  logic [47:0] dest,
  input  logic [47:0] station_mac,
  input  logic        promisc,
  input  logic        accept_mcast,
  output logic        match,
  output logic        is_bcast
);
  always_comb begin
    is_bcast = (dest == BCAST_MAC);
    match    = promisc | (dest == station_mac) | is_bcast | (accept_mcast & dest[MCAST_BIT]);
  end
endmodule

// File: rtl/rx_frame_controller.sv
// Arms frame_reception, filters each parsed header and offers it to the host via a one-entry buffer.
// Header/counters update two edges after rx_done; a full buffer with no pop drops the frame (counted).
module rx_frame_controller
  import rx_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_enable,
  input  logic             promisc,
  input  logic             accept_mcast,
  input  logic [47:0]      station_mac,
  output logic             mac_rx_en,
  input  logic [47:0]      mac_dest,
  input  logic [47:0]      mac_src,
  input  logic [15:0]      mac_type,
  input  logic             mac_frame_valid,
  input  logic             mac_rx_done,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  output logic [47:0]      hdr_dest,
  output logic [47:0]      hdr_src,
  output logic [15:0]      hdr_type,
  output logic             hdr_bcast,
  output logic [CNT_W-1:0] cnt_accept,
  output logic [CNT_W-1:0] cnt_drop_filter,
  output logic [CNT_W-1:0] cnt_drop_overflow,
  output logic [CNT_W-1:0] cnt_drop_error,
  output logic             busy
);
  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        state;
  hdr_t          stg;
  logic          stg_valid;
  logic [GW-1:0] gap_cnt;
  logic          match;
  logic          is_bcast;
  logic          pop;
  logic          buf_free;

  mac_addr_filter u_filter (
    .dest         (stg.dest),
    .station_mac  (station_mac),
    .promisc      (promisc),
    .accept_mcast (accept_mcast),
    .match        (match),
    .is_bcast     (is_bcast)
  );

  assign pop      = hdr_valid & hdr_ready;
  assign buf_free = ~hdr_valid | hdr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      mac_rx_en         <= 1'b0;
      busy              <= 1'b0;
      stg               <= '0;
      stg_valid         <= 1'b0;
      gap_cnt           <= '0;
      hdr_valid         <= 1'b0;
      hdr_dest          <= '0;
      hdr_src           <= '0;
      hdr_type          <= '0;
      hdr_bcast         <= 1'b0;
      cnt_accept        <= '0;
      cnt_drop_filter   <= '0;
      cnt_drop_overflow <= '0;
      cnt_drop_error    <= '0;
    end else begin
      // A pop clears the buffer unless EVAL reloads it on the same edge below.
      if (pop) hdr_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (ctrl_enable) begin
            state     <= RECEIVE;
            mac_rx_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RECEIVE: begin
          if (mac_rx_done) begin
            stg.dest  <= mac_dest;
            stg.src   <= mac_src;
            stg.etype <= mac_type;
            stg_valid <= mac_frame_valid;
            state     <= EVAL;
            mac_rx_en <= 1'b0;
          end
        end
        EVAL: begin
          state   <= GAP;
          gap_cnt <= '0;
          if (!stg_valid) begin
            if (cnt_drop_error != '1) cnt_drop_error <= cnt_drop_error + CNT_W'(1);
          end else if (!match) begin
            if (cnt_drop_filter != '1) cnt_drop_filter <= cnt_drop_filter + CNT_W'(1);
          end else if (buf_free) begin
            hdr_valid <= 1'b1;
            hdr_dest  <= stg.dest;
            hdr_src   <= stg.src;
            hdr_type  <= stg.etype;
            hdr_bcast <= is_bcast;
            if (cnt_accept != '1) cnt_accept <= cnt_accept + CNT_W'(1);
          end else begin
            if (cnt_drop_overflow != '1) cnt_drop_overflow <= cnt_drop_overflow + CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (ctrl_enable) begin
              state     <= RECEIVE;
              mac_rx_en <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          mac_rx_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rx_frame_controller.sv
// Randomized scoreboard bench for rx_frame_controller (GAP_CYCLES=2) with a CNT_W=2 twin for saturation.
module tb_rx_frame_controller;
  localparam int          GAP     = 2;
  localparam logic [47:0] STATION = 48'h0123_4567_89AB;
  localparam logic [47:0] ALL1    = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_enable = 1'b0, promisc = 1'b0, accept_mcast = 1'b0;
  logic [47:0] station_mac = STATION;
  logic [47:0] mac_dest = '0, mac_src = '0;
  logic [15:0] mac_type = '0;
  logic        mac_frame_valid = 1'b0, mac_rx_done = 1'b0, hdr_ready = 1'b0;

  logic        rx_en, hdr_valid, hdr_bcast, busy;
  logic [47:0] hdr_dest, hdr_src;
  logic [15:0] hdr_type;
  logic [15:0] c_acc, c_filt, c_ovf, c_err;

  logic        s_rx_en, s_hdr_valid, s_hdr_bcast, s_busy;
  logic [47:0] s_hdr_dest, s_hdr_src;
  logic [15:0] s_hdr_type;
  logic [1:0]  s_acc, s_filt, s_ovf, s_err;

  always #5 clk = ~clk;

  rx_frame_controller #(.CNT_W(16), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst(rst), .ctrl_enable(ctrl_enable), .promisc(promisc), .accept_mcast(accept_mcast),
    .station_mac(station_mac), .mac_rx_en(rx_en), .mac_dest(mac_dest), .mac_src(mac_src),
    .mac_type(mac_type), .mac_frame_valid(mac_frame_valid), .mac_rx_done(mac_rx_done),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_dest(hdr_dest), .hdr_src(hdr_src),
    .hdr_type(hdr_type), .hdr_bcast(hdr_bcast), .cnt_accept(c_acc), .cnt_drop_filter(c_filt),
    .cnt_drop_overflow(c_ovf), .cnt_drop_error(c_err), .busy(busy)
  );

  rx_frame_controller #(.CNT_W(2), .GAP_CYCLES(GAP)) u_sat (
    .clk(clk), .rst(rst), .ctrl_enable(ctrl_enable), .promisc(promisc), .accept_mcast(accept_mcast),
    .station_mac(station_mac), .mac_rx_en(s_rx_en), .mac_dest(mac_dest), .mac_src(mac_src),
    .mac_type(mac_type), .mac_frame_valid(mac_frame_valid), .mac_rx_done(mac_rx_done),
    .hdr_valid(s_hdr_valid), .hdr_ready(hdr_ready), .hdr_dest(s_hdr_dest), .hdr_src(s_hdr_src),
    .hdr_type(s_hdr_type), .hdr_bcast(s_hdr_bcast), .cnt_accept(s_acc), .cnt_drop_filter(s_filt),
    .cnt_drop_overflow(s_ovf), .cnt_drop_error(s_err), .busy(s_busy)
  );

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    logic        bcast;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   m_acc = 0, m_filt = 0, m_ovf = 0, m_err = 0;
  bit   m_full = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_acc"},    64'(c_acc),  64'(m_acc));
    chk({tag, "_filt"},   64'(c_filt), 64'(m_filt));
    chk({tag, "_ovf"},    64'(c_ovf),  64'(m_ovf));
    chk({tag, "_err"},    64'(c_err),  64'(m_err));
    chk({tag, "_s_acc"},  64'(s_acc),  64'(sat3(m_acc)));
    chk({tag, "_s_filt"}, 64'(s_filt), 64'(sat3(m_filt)));
    chk({tag, "_s_ovf"},  64'(s_ovf),  64'(sat3(m_ovf)));
    chk({tag, "_s_err"},  64'(s_err),  64'(sat3(m_err)));
  endtask

  // Scoreboard monitor: every host handshake must deliver the oldest expected header.
  always @(negedge clk) begin
    if (!rst && hdr_valid && hdr_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h expected=none", hdr_dest);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pop_dest",  64'(hdr_dest),  64'(e.dest));
        chk("pop_src",   64'(hdr_src),   64'(e.src));
        chk("pop_type",  64'(hdr_type),  64'(e.etype));
        chk("pop_bcast", 64'(hdr_bcast), 64'(e.bcast));
        chk("pop_s_hdr", {s_hdr_valid, s_hdr_bcast, s_hdr_type, s_hdr_dest[45:0]},
            {1'b1, e.bcast, e.etype, e.dest[45:0]});
        chk("pop_s_src", 64'(s_hdr_src), 64'(e.src));
      end
    end
  end

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench stopped early");
  endtask

  task automatic arm();
    int n = 0;
    while (!rx_en && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_en) begin
      checks++;
      failures++;
      $display("FAIL arm_timeout actual=rx_en_low expected=rx_en_high");
      finish_now();
    end
  endtask

  // Caller guarantees rx_en is high in the current cycle (we are #1 after a rising edge).
  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input bit fv, input bit r, input bit junk, input bit chk_gap);
    bit is_b, match, accepted, full_before;
    int low;
    mac_dest = d; mac_src = s; mac_type = t; mac_frame_valid = fv; mac_rx_done = 1'b1;
    @(posedge clk); #1;
    // A pulse during EVAL must be ignored.
    mac_rx_done = junk; mac_frame_valid = 1'b0; mac_dest = ~d;
    hdr_ready = r;
    full_before = m_full;
    chk("eval_hdr_valid", 64'(hdr_valid), 64'(full_before));
    chk("eval_rx_en", 64'(rx_en), 64'd0);
    chk("eval_acc_hold", 64'(c_acc), 64'(m_acc));

    is_b     = (d == ALL1);
    match    = promisc || (d == station_mac) || is_b || (accept_mcast && d[40]);
    accepted = 1'b0;
    if (!fv) m_err++;
    else if (!match) m_filt++;
    else if (r || !m_full) begin
      m_acc++;
      accepted = 1'b1;
      m_full   = 1'b1;
    end else m_ovf++;
    if (r) m_full = 1'b0;

    @(posedge clk); #1;
    mac_rx_done = 1'b0;
    if (accepted) q.push_back('{dest: d, src: s, etype: t, bcast: is_b});
    chk("post_hdr_valid", 64'(hdr_valid), 64'(accepted ? 1'b1 : (r ? 1'b0 : full_before)));
    chk("post_s_hdr_valid", 64'(s_hdr_valid), 64'(accepted ? 1'b1 : (r ? 1'b0 : full_before)));
    if (accepted) begin
      chk("post_hdr_dest", 64'(hdr_dest), 64'(d));
      chk("post_hdr_bcast", 64'(hdr_bcast), 64'(is_b));
    end
    chk_counters("post");

    if (chk_gap) begin
      low = 2;
      while (!rx_en && low < 50) begin
        @(posedge clk); #1;
        if (!rx_en) low++;
      end
      chk("rearm_gap", 64'(low), 64'(GAP + 1));
    end
  endtask

  initial begin
    logic [63:0] rnd;
    logic [47:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {rx_en, hdr_valid, hdr_bcast, busy, s_rx_en, s_busy, hdr_type},
        64'd0);
    chk("rst_hdr", 64'(hdr_dest | hdr_src), 64'd0);
    chk_counters("rst");
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_no_arm", {rx_en, busy}, 64'd0);

    ctrl_enable = 1'b1;
    arm();
    chk("busy_on", 64'(busy), 64'd1);

    // Directed cases
    send_frame(STATION, 48'h0A0B_0C0D_0E0F, 16'h0800, 1, 1, 0, 1);
    arm(); send_frame(ALL1, 48'h1111_2222_3333, 16'h0806, 1, 1, 0, 1);
    arm(); send_frame(48'h0200_0000_0001, 48'h4, 16'h86DD, 1, 1, 0, 1);
    promisc = 1'b1;
    arm(); send_frame(48'h0200_0000_0001, 48'h4, 16'h86DD, 1, 1, 0, 1);
    promisc = 1'b0;
    arm(); send_frame(STATION, 48'hA1, 16'h0001, 1, 0, 0, 1);
    arm(); send_frame(STATION, 48'hA2, 16'h0002, 1, 0, 0, 1);
    arm(); send_frame(STATION, 48'hA3, 16'h0003, 1, 1, 0, 1);
    arm(); send_frame(STATION, 48'hB1, 16'h0004, 0, 1, 0, 1);
    accept_mcast = 1'b1;
    arm(); send_frame(48'h0100_5E00_0001, 48'hC1, 16'h0800, 1, 1, 1, 1);
    accept_mcast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      arm(); send_frame(48'h0200_0000_0001 + 48'(i), 48'hD0, 16'h0800, 1, 1, 0, 1);
    end

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      promisc      = ($urandom_range(0, 5) == 0);
      accept_mcast = $urandom_range(0, 1) == 1;
      rnd = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: d = STATION;
        1: d = ALL1;
        2: d = rnd[47:0] | 48'h0100_0000_0000;
        default: d = rnd[47:0] & 48'hFEFF_FFFF_FFFF;
      endcase
      arm();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_frame(d, {rnd[31:0], rnd[63:48]}, rnd[15:0], $urandom_range(0, 7) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, 1);
    end

    // Enable dropped mid-receive: frame completes, then the block idles.
    arm();
    ctrl_enable = 1'b0;
    send_frame(STATION, 48'hE1, 16'h0800, 1, 1, 0, 0);
    repeat (10) begin @(posedge clk); #1; end
    chk("disable_idle", {rx_en, busy, s_rx_en, s_busy}, 64'd0);

    hdr_ready = 1'b1;
    m_full = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("drain_queue", 64'(q.size()), 64'd0);

    // Async reset while receiving with a full buffer.
    ctrl_enable = 1'b1;
    arm();
    send_frame(STATION, 48'hF1, 16'h0800, 1, 0, 0, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("arst_ctrl", {rx_en, hdr_valid, busy, hdr_bcast, s_rx_en, s_hdr_valid}, 64'd0);
    chk("arst_hdr", 64'(hdr_dest | hdr_src), 64'd0);
    q.delete();
    m_acc = 0; m_filt = 0; m_ovf = 0; m_err = 0; m_full = 1'b0;
    chk_counters("arst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    arm();
    send_frame(ALL1, 48'h77, 16'h0800, 1, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
